cnt_delta_rx: RTL and testbench
===============================

// Module: cnt_delta_rx
// PURPOSE
// - Consumer side of the 32-bit cycle-stamp stream in the OpenCL RTL library.
// - Accepts timestamps on the ivalid/oready handshake.
// - Emits the modulo-2^32 difference from the previous accepted stamp, i.e. elapsed clock cycles.
// - Results are buffered in a FIFO; downstream backpressure (iready) is honoured.
// - Stall-capable library function; oready deasserts when the buffer is full.
// PARAMETERS
// - DEPTH     4   result FIFO entries; power of 2, >=2
// - AW        2   FIFO address width; must equal log2(DEPTH)
// PORTS
// - clock      in   1   clock; all logic on posedge
// - resetn     in   1   reset, synchronous, active-low
// - ivalid     in   1   upstream stamp valid
// - oready     out  1   this block can accept a stamp (FIFO not full)
// - stamp      in   32  timestamp from upstream counter
// - ovalid     out  1   delta valid at FIFO head
// - iready     in   1   downstream accepts delta
// - delta      out  32  stamp[n] - stamp[n-1] mod 2^32; 0 for first stamp after reset
// - max_delta  out  32  largest delta produced since reset (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state while resetn=0 at a posedge:
//   - FIFO empty, primed=0, prev=0, max=0.
//   - Outputs: ovalid=0, delta=0, oready=1, max_delta=0.
// - Accept: ivalid & oready at posedge.
//   - delta_new = primed ? stamp - prev : 0.
//   - Push delta_new; prev<=stamp; primed<=1.
// - Pop: ovalid & iready at posedge; head advances.
// - ovalid = FIFO not empty. delta = head entry; stable while ovalid & !iready.
// - Latency: stamp accepted at edge N gives ovalid=1 in cycle N+1 if FIFO was empty.
//   - Throughput 1/cycle with iready held 1.
// - Full: oready=0 when count==DEPTH. ivalid is ignored; prev and primed are unchanged.
// - Empty: pop is impossible; iready is ignored.
// - Push and pop in the same cycle: count unchanged.
//   - Legal at any count except full, where push is blocked.
// - oready depends only on the registered count (no comb path from iready).
// - Wrap: subtraction is 32-bit unsigned, modulo 2^32.
//   - Example: prev=0xFFFFFFFE, stamp=0x00000003 -> delta=5.
// - Equal stamps give delta=0. This is legal and is not flagged.
// - Reset mid-operation: all entries are discarded within the same cycle.
//   - ovalid=0 the cycle after the reset edge.
//   - The first stamp after reset again yields delta=0.
// - Pointers: AW+1 bits wide. count = wptr - rptr.
// CONFIGURATION
// - CNT_DELTA_MAX_EN defined:
//   - On each push, max <= (delta_new > max) ? delta_new : max.
//   - The first (zero) delta counts as a candidate.
//   - max_delta = max, registered; updates the cycle after the push.
// - CNT_DELTA_MAX_EN undefined:
//   - max_delta tied to 32'd0; no compare logic.
//   - The port is always present.
// TESTING
// - Reset, then stamps 1,2,3,10 with iready=1 -> delta 0,1,1,7, each 1 cycle after accept.
// - iready=0, push 5 stamps with DEPTH=4 -> oready=0 after 4th; 5th held.
//   - Raise iready: 4 deltas out in order, then 5th accepted.
// - prev=0xFFFFFFFE, stamp=0x00000003 -> delta=0x00000005.
// - Full FIFO with ivalid & iready both high -> pop only this cycle; push accepted the next cycle.
// - 3 entries queued, resetn=0 one cycle -> ovalid=0, oready=1.
//   - Next stamp 100 -> delta=0.
// - With CNT_DELTA_MAX_EN, deltas 0,7,3 -> max_delta 0,7,7.
//   - Without the macro, max_delta stays 0.

Source files
------------

// File: rtl/cnt_delta_rx.sv
// rtl/cnt_delta_rx.sv - cycle-stamp consumer: emits elapsed cycles between accepted stamps through a result FIFO
// Optional running maximum of deltas enabled by CNT_DELTA_MAX_EN.
module cnt_delta_rx #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ivalid,
  output logic        oready,
  input  logic [31:0] stamp,
  output logic        ovalid,
  input  logic        iready,
  output logic [31:0] delta,
  output logic [31:0] max_delta
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);

  logic [31:0] mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] count;
  logic [31:0] prev;
  logic        primed;
  logic        push;
  logic        pop;
  logic [31:0] delta_new;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count  = wptr - rptr;
  assign oready = (count != FULL_COUNT);
  assign ovalid = (wptr != rptr);

  assign push = ivalid & oready;
  assign pop  = ovalid & iready;

  // Unsigned 32-bit subtraction wraps naturally modulo 2^32.
  assign delta_new = primed ? (stamp - prev) : 32'd0;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wptr   <= '0;
      rptr   <= '0;
      prev   <= 32'd0;
      primed <= 1'b0;
    end else begin
      if (push) begin
        wptr   <= wptr + PTR_ONE;
        prev   <= stamp;
        primed <= 1'b1;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (resetn && push) begin
      mem[wptr[AW-1:0]] <= delta_new;
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign delta = ovalid ? mem[rptr[AW-1:0]] : 32'd0;

`ifdef CNT_DELTA_MAX_EN
  logic [31:0] max_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      max_q <= 32'd0;
    end else if (push && (delta_new > max_q)) begin
      max_q <= delta_new;
    end
  end

  assign max_delta = max_q;
`else
  assign max_delta = 32'd0;
`endif

endmodule

// File: tb/tb_cnt_delta_rx.sv
// tb/tb_cnt_delta_rx.sv - directed self-checking bench for cnt_delta_rx (DEPTH=4)
module tb_cnt_delta_rx;

  logic        clock = 1'b0;
  logic        resetn;
  logic        ivalid;
  logic        oready;
  logic [31:0] stamp;
  logic        ovalid;
  logic        iready;
  logic [31:0] delta;
  logic [31:0] max_delta;

  int checks_total  = 0;
  int checks_passed = 0;

  cnt_delta_rx #(.DEPTH(4), .AW(2)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .ivalid    (ivalid),
    .oready    (oready),
    .stamp     (stamp),
    .ovalid    (ovalid),
    .iready    (iready),
    .delta     (delta),
    .max_delta (max_delta)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one edge; inputs and samples both sit 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] max_exp(input logic [31:0] v);
`ifdef CNT_DELTA_MAX_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  logic [31:0] stream_stamps [4] = '{32'd1, 32'd2, 32'd3, 32'd10};
  logic [31:0] stream_deltas [4] = '{32'd0, 32'd1, 32'd1, 32'd7};
  logic [31:0] fill_stamps   [4] = '{32'd20, 32'd25, 32'd31, 32'd40};
  logic [31:0] drain_deltas  [5] = '{32'd10, 32'd5, 32'd6, 32'd9, 32'd10};

  initial begin
    resetn = 1'b0; ivalid = 1'b0; iready = 1'b0; stamp = 32'd0;
    step(); step();
    check("rst_ovalid", {31'd0, ovalid}, 32'd0);
    check("rst_oready", {31'd0, oready}, 32'd1);
    check("rst_delta", delta, 32'd0);
    check("rst_max", max_delta, 32'd0);

    // Streaming with iready high: each delta appears one cycle after accept.
    resetn = 1'b1; iready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ivalid = 1'b1; stamp = stream_stamps[i];
      step();
      check($sformatf("stream_ovalid%0d", i), {31'd0, ovalid}, 32'd1);
      check($sformatf("stream_delta%0d", i), delta, stream_deltas[i]);
    end
    ivalid = 1'b0;
    step();
    check("stream_drained", {31'd0, ovalid}, 32'd0);
    check("stream_max", max_delta, max_exp(32'd7));

    // Fill to full with downstream stalled.
    iready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_oready%0d", i), {31'd0, oready}, 32'd1);
      ivalid = 1'b1; stamp = fill_stamps[i];
      step();
    end
    check("full_oready", {31'd0, oready}, 32'd0);
    check("full_head", delta, 32'd10);
    stamp = 32'd50;
    step();
    check("full_held_oready", {31'd0, oready}, 32'd0);
    check("full_held_head", delta, 32'd10);

    // Full with ivalid and iready: pop only, push lands on the following edge.
    iready = 1'b1;
    step();
    check("full_pop_oready", {31'd0, oready}, 32'd1);
    check("full_pop_head", delta, drain_deltas[1]);
    step();
    ivalid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      check($sformatf("drain_ovalid%0d", i), {31'd0, ovalid}, 32'd1);
      check($sformatf("drain_delta%0d", i), delta, drain_deltas[i]);
      step();
    end
    check("drain_empty", {31'd0, ovalid}, 32'd0);

    // Wrap across 2^32.
    ivalid = 1'b1; stamp = 32'hFFFF_FFFE;
    step();
    check("wrap_first", delta, 32'hFFFF_FFCC);
    stamp = 32'h0000_0003;
    step();
    check("wrap_delta", delta, 32'h0000_0005);
    ivalid = 1'b0;
    step();
    check("wrap_max", max_delta, max_exp(32'hFFFF_FFCC));

    // Reset with three entries queued.
    iready = 1'b0; ivalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stamp = 32'd7 + 32'(i);
      step();
    end
    ivalid = 1'b0;
    check("queued_ovalid", {31'd0, ovalid}, 32'd1);
    resetn = 1'b0;
    step();
    check("midrst_ovalid", {31'd0, ovalid}, 32'd0);
    check("midrst_oready", {31'd0, oready}, 32'd1);
    check("midrst_delta", delta, 32'd0);
    check("midrst_max", max_delta, 32'd0);

    // Post-reset: first stamp gives 0, running max tracks 0,7,7.
    resetn = 1'b1; iready = 1'b1; ivalid = 1'b1; stamp = 32'd100;
    step();
    check("post_delta0", delta, 32'd0);
    check("post_max0", max_delta, max_exp(32'd0));
    stamp = 32'd107;
    step();
    check("post_delta1", delta, 32'd7);
    check("post_max1", max_delta, max_exp(32'd7));
    stamp = 32'd110;
    step();
    check("post_delta2", delta, 32'd3);
    check("post_max2", max_delta, max_exp(32'd7));
    stamp = 32'd110;
    step();
    check("equal_delta", delta, 32'd0);
    ivalid = 1'b0;
    step();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
